// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and types for the single-clock FIFO and its storage array.
package sync_fifo_pkg;

    // Ceiling log2, usable in constant expressions (port widths, localparams).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; (1 << i) < value; i++) begin
            result = i + 1;
        end
        return result;
    endfunction

    localparam int DEPTH_DFLT = 256;
    localparam int PTR_W      = clog2(DEPTH_DFLT);
    localparam int CNT_W      = PTR_W + 1;

    // Post-reset sequencing: both sides stay busy until the counter expires.
    typedef enum logic {
        ST_BUSY  = 1'b0,
        ST_READY = 1'b1
    } rst_state_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port DATA_W x DEPTH array with one write port and a registered read port.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEPTH_DFLT
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array and its read register carry no reset so the tools can map them onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with vendor-compatible handshake, reset-busy sequencing and debug status.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = DEPTH_DFLT,
    parameter int AF_LEVEL     = DEPTH - 1,
    parameter int AE_LEVEL     = 1,
    parameter int RST_BUSY_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       din,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       dout,
    output logic                    valid,
    output logic                    full,
    output logic                    almost_full,
    output logic                    empty,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   data_count,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    wr_rst_busy,
    output logic                    rd_rst_busy
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (clog2(RST_BUSY_CYC + 1) > 0) ? clog2(RST_BUSY_CYC + 1) : 1;

    rst_state_e        state_q, state_d;
    logic [BW-1:0]     busy_cnt_q, busy_cnt_d;
    logic              busy;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              ae_q, ae_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              dout_live_q, dout_live_d;
    logic              wa, ra;
    logic [DATA_W-1:0] ram_rdata;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BUSY;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // NOTE: every signal assigned in combinational logic gets a default first, so no latches form.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        case (state_q)
            ST_BUSY: begin
                if (busy_cnt_q == BW'(RST_BUSY_CYC - 1)) begin
                    state_d = ST_READY;
                end else begin
                    busy_cnt_d = busy_cnt_q + BW'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_BUSY;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_BUSY);
    end

    assign wa = wr_en & ~full_q  & ~busy;
    assign ra = rd_en & ~empty_q & ~busy;

    // Flags decode the post-edge occupancy, so they are exact the cycle after each operation.
    always_comb begin
        wr_ptr_d    = wa ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = ra ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(wa) - CW'(ra);
        full_d      = (state_d == ST_BUSY) | (count_d == CW'(DEPTH));
        empty_d     = (count_d == '0);
        af_d        = (count_d >= CW'(AF_LEVEL));
        ae_d        = (count_d <= CW'(AE_LEVEL));
        valid_d     = ra;
        ovf_d       = wr_en & (full_q | busy);
        unf_d       = rd_en & (empty_q | busy);
        dout_live_d = dout_live_q | ra;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b1;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            dout_live_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            dout_live_q <= dout_live_d;
        end
    end

    // Pointers always differ when count is 1, so a simultaneous read and write never collide.
    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wa),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ra),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // The RAM read register has no reset; dout reads as zero until the first accepted read.
    assign dout         = dout_live_q ? ram_rdata : '0;
    assign valid        = valid_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign wr_rst_busy  = busy;
    assign rd_rst_busy  = busy;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and random stimulus for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;
    localparam int BUSY_N = 4;

    logic             clk;
    logic             rst_n;
    logic [DATA_W-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [DATA_W-1:0] dout;
    logic             valid;
    logic             full;
    logic             almost_full;
    logic             empty;
    logic             almost_empty;
    logic [8:0]       data_count;
    logic             overflow;
    logic             underflow;
    logic             wr_rst_busy;
    logic             rd_rst_busy;

    sync_fifo #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .AF_LEVEL     (DEPTH - 1),
        .AE_LEVEL     (1),
        .RST_BUSY_CYC (BUSY_N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .valid        (valid),
        .full         (full),
        .almost_full  (almost_full),
        .empty        (empty),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow),
        .wr_rst_busy  (wr_rst_busy),
        .rd_rst_busy  (rd_rst_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model state
    int          m_cnt;
    int          m_busy_left;
    logic [7:0]  m_dout;
    logic        m_valid;
    logic        m_ovf;
    logic        m_unf;
    logic [7:0]  sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt       = 0;
        m_busy_left = BUSY_N;
        m_dout      = 8'h00;
        m_valid     = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        sb.delete();
    endtask

    task automatic check_state();
        logic m_busy;
        m_busy = (m_busy_left > 0);
        check("valid",        {31'd0, valid},        {31'd0, m_valid});
        check("dout",         {24'd0, dout},         {24'd0, m_dout});
        check("data_count",   {23'd0, data_count},   m_cnt);
        check("full",         {31'd0, full},         {31'd0, (m_busy || m_cnt == DEPTH)});
        check("empty",        {31'd0, empty},        {31'd0, (m_cnt == 0)});
        check("almost_full",  {31'd0, almost_full},  {31'd0, (m_cnt >= DEPTH - 1)});
        check("almost_empty", {31'd0, almost_empty}, {31'd0, (m_cnt <= 1)});
        check("overflow",     {31'd0, overflow},     {31'd0, m_ovf});
        check("underflow",    {31'd0, underflow},    {31'd0, m_unf});
        check("wr_rst_busy",  {31'd0, wr_rst_busy},  {31'd0, m_busy});
        check("rd_rst_busy",  {31'd0, rd_rst_busy},  {31'd0, m_busy});
    endtask

    // One clock of stimulus: drive at negedge, advance the model, check after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic busy_now;
        logic wa;
        logic ra;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        busy_now = (m_busy_left > 0);
        wa    = w && !busy_now && (m_cnt < DEPTH);
        ra    = r && !busy_now && (m_cnt > 0);
        m_ovf = w && (busy_now || m_cnt == DEPTH);
        m_unf = r && (busy_now || m_cnt == 0);
        m_valid = ra;
        if (ra) m_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        m_cnt = m_cnt + int'(wa) - int'(ra);
        if (m_busy_left > 0) m_busy_left--;
        @(posedge clk);
        #1;
        check_state();
    endtask

    logic [7:0] data;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        model_reset();

        // Reset held for three cycles, then released between edges.
        repeat (3) @(posedge clk);
        #1;
        check_state();
        rst_n = 1'b1;

        // Write during busy is dropped and flagged; busy and full fall together after 4 edges.
        step(1'b1, 1'b0, 8'h11);
        for (int i = 0; i < BUSY_N + 1; i++) step(1'b0, 1'b0, 8'h00);

        // Fill to full, then one rejected write.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 8'h00);

        // Drain in order, then one read past empty.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Simultaneous read/write at empty, then at full.
        step(1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b0, 8'h00);

        // Random streaming across many pointer wraps.
        data = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), data);
            data = data + 8'd1;
        end

        // Drain, refill to 37 entries, then reset asynchronously between edges.
        for (int i = 0; i < DEPTH + 1 && m_cnt > 0; i++) step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hF0);
        check("count_before_reset", {23'd0, data_count}, 32'd37);
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        #1;
        check_state();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst_n = 1'b1;

        // Busy sequence repeats, old data is gone, FIFO works again.
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < BUSY_N; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b1, 8'h3D);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock RTL FIFO that serves as the storage end of the fifo_wr/fifo_rd handshake. It stands in for the vendor FIFO IP wherever writer and reader share one clock. Its port semantics are a drop-in match for that pair: din/wr_en/full/almost_full/wr_rst_busy on the write side, and rd_en/dout/empty/almost_empty/rd_rst_busy on the read side. It adds data count, overflow, underflow and valid outputs for bring-up and debug.

Parameters:
DATA_W, 8, data word width
DEPTH, 256, number of entries; power of two, minimum 4
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL
RST_BUSY_CYC, 4, cycles after reset release during which the *_rst_busy outputs stay high

Ports:
clk  in  1  sole clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
din  in  DATA_W  write data
wr_en  in  1  write request
rd_en  in  1  read request
dout  out  DATA_W  read data, registered
valid  out  1  dout was updated by an accepted read on this edge
full  out  1  no write will be accepted
almost_full  out  1  count >= AF_LEVEL
empty  out  1  no read will be accepted
almost_empty  out  1  count <= AE_LEVEL
data_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: previous cycle had wr_en while full or wr_rst_busy
underflow  out  1  one-cycle pulse: previous cycle had rd_en while empty or rd_rst_busy
wr_rst_busy  out  1  write side not ready
rd_rst_busy  out  1  read side not ready

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Values while rst_n=0:
  - wr_ptr, rd_ptr and count = 0
  - dout = 0, valid = 0
  - empty = 1, almost_empty = 1
  - full = 1, almost_full = 0
  - data_count = 0, overflow = 0, underflow = 0
  - wr_rst_busy = 1, rd_rst_busy = 1
- Busy release:
  - After rst_n rises, a counter runs RST_BUSY_CYC cycles. Both busy outputs then drop on the same edge.
  - full drops on that same edge.
  - Memory contents are not cleared.
- Write accept: wa = wr_en & ~full & ~wr_rst_busy. On wa, mem[wr_ptr] <= din and wr_ptr increments.
- Read accept: ra = rd_en & ~empty & ~rd_rst_busy. On ra:
  - dout <= mem[rd_ptr] on the same edge, giving 1-cycle latency (standard mode, no first-word fall-through).
  - rd_ptr increments; valid = 1 for that cycle.
- dout holds its value when there is no read.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update: count <= count + wa - ra.
- Flags are registered and decoded from the next count:
  - full = (next == DEPTH)
  - empty = (next == 0)
  - almost_full = (next >= AF_LEVEL)
  - almost_empty = (next <= AE_LEVEL)
  - data_count = next
  - Flags are therefore exact on the cycle after the operation, with no extra lag.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected, overflow pulses; full drops on the next edge.
  - Empty: write accepted, read rejected, underflow pulses; empty drops on the next edge.
  - Count == 1: both accepted; dout gets the old word and the new word is stored, with no collision. This requires a RAM with read-before-write behaviour or different addresses. Addresses always differ here because wr_ptr != rd_ptr when count is 1.
- Rejected requests never modify pointers, memory or dout.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), data is discarded, and the busy sequence reruns.

Decomposition:
- Package sync_fifo_pkg holds:
  - the function clog2
  - the localparam PTR_W = clog2(DEPTH)
  - the localparam CNT_W = PTR_W+1
- One sub-module, sync_fifo_ram: simple dual-port memory, DATA_W x DEPTH.
  - One write port: we, waddr, wdata.
  - One registered read port: re, raddr, rdata.
  - rdata holds when re=0.
  - No reset on the array; infers block RAM.
- Top-level sync_fifo contains the pointers, count, flag registers, busy counter and error pulses.

Test Plan:
- Reset release: hold rst_n=0 for 3 cycles, then release. Expect wr_rst_busy=rd_rst_busy=full=1 for exactly 4 cycles, then all three drop together; empty=1, data_count=0. A wr_en pulse during busy is not stored and overflow pulses.
- Fill to full (DEPTH=256): write 0x00..0xFF on consecutive cycles.
  - almost_full rises after the write of 0xFE (count 255).
  - full rises after the write of 0xFF, data_count=256.
  - A 257th write of 0xAA is rejected and overflow pulses once.
- Drain in order: from full, assert rd_en for 256 cycles. dout sequence is 0x00..0xFF, each valid one cycle after rd_en. almost_empty rises at count 1; empty rises after the last read. One more rd_en gives underflow=1 and dout stays 0xFF.
- Simultaneous at boundaries:
  - Empty plus wr_en=rd_en=1 with din 0x5A: count becomes 1, no valid, underflow pulses.
  - Full plus both enabled: count becomes 255, valid=1, overflow pulses.
- Streaming and wraparound: run 1000 cycles of random wr_en/rd_en (50/50) with incrementing data. The scoreboard must match every valid dout. data_count must equal the model count every cycle, and pointers must wrap without corruption.
- Asynchronous reset mid-stream: at count 37, pulse rst_n low between clock edges. Outputs must take reset values before the next edge (empty=1, data_count=0, dout=0), then the busy sequence repeats.
